// File: rtl/serial_add_pkg.sv
// serial_add_pkg: FSM state encoding and default full_adder_v function codes shared by the sequencer and cell.
package serial_add_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    CARRY = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam logic [1:0] CODE_SUM   = 2'b00;
  localparam logic [1:0] CODE_CARRY = 2'b01;
endpackage

// File: rtl/full_adder_v.sv
// full_adder_v: combinational full-adder cell; code selects whether f carries the sum or the carry bit.
module full_adder_v
  import serial_add_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [1:0] code,
  output logic       f
);
  always_comb f = (code == CODE_SUM) ? (a ^ b ^ c) :
                  (code == CODE_CARRY) ? ((a & b) | (a & c) | (b & c)) : 1'b0;
endmodule

// File: rtl/serial_add_shreg_v.sv
// serial_add_shreg_v: parallel-load, right-shift register with serial in at the MSB and serial out from the LSB.
module serial_add_shreg_v #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         si,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         so
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {si, q[W-1:1]};
  assign so = q[0];
endmodule

// File: rtl/serial_add_seq_v.sv
// serial_add_seq_v: bit-serial adder sequencer time-multiplexing one full_adder_v cell (sum then carry per bit).
// Optional signed-overflow output o_ovf is enabled by defining SERIAL_ADD_SEQ_OVF_EN.
module serial_add_seq_v
  import serial_add_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter logic [1:0] CODE_SUM   = serial_add_pkg::CODE_SUM,
  parameter logic [1:0] CODE_CARRY = serial_add_pkg::CODE_CARRY
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_a,
  output logic             o_b,
  output logic             o_c,
  output logic [1:0]       o_code,
  input  logic             i_f,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADD_SEQ_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_cout
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic carry, accept, busy, a_so, b_so, unused_sum_so;
  logic [WIDTH-1:0] sum_q, unused_a_q, unused_b_q;
  assign accept = (state == IDLE) && i_start;
  assign busy   = (state == SUM) || (state == CARRY);
  assign o_busy = busy;
  assign o_done = state == DONE;
  assign o_a    = busy & a_so;
  assign o_b    = busy & b_so;
  assign o_c    = busy & carry;
  assign o_code = (state == CARRY) ? CODE_CARRY : CODE_SUM;
  serial_add_shreg_v #(.W(WIDTH)) u_a (
    .clk(i_clk), .rst(i_rst), .load(accept), .shift(state == CARRY), .si(1'b0),
    .d(i_a), .q(unused_a_q), .so(a_so)
  );
  serial_add_shreg_v #(.W(WIDTH)) u_b (
    .clk(i_clk), .rst(i_rst), .load(accept), .shift(state == CARRY), .si(1'b0),
    .d(i_b), .q(unused_b_q), .so(b_so)
  );
  // sum bits enter at the MSB so after WIDTH shifts bit 0 sits in the LSB
  serial_add_shreg_v #(.W(WIDTH)) u_sum (
    .clk(i_clk), .rst(i_rst), .load(accept), .shift(state == SUM), .si(i_f),
    .d('0), .q(sum_q), .so(unused_sum_so)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      o_sum  <= '0;
      o_cout <= 1'b0;
`ifdef SERIAL_ADD_SEQ_OVF_EN
      o_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (i_start) begin
          carry <= i_cin;
          cnt   <= '0;
          state <= SUM;
        end
        SUM: state <= CARRY;
        CARRY: begin
          carry <= i_f;
          cnt   <= cnt + 1'b1;
          state <= (cnt == CW'(WIDTH - 1)) ? DONE : SUM;
          if (cnt == CW'(WIDTH - 1)) begin
            o_sum  <= sum_q;
            o_cout <= i_f;
`ifdef SERIAL_ADD_SEQ_OVF_EN
            o_ovf  <= carry ^ i_f;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_add_seq_v.sv
// tb_serial_add_seq_v: scoreboard bench for serial_add_seq_v wired to a full_adder_v cell.
module tb_serial_add_seq_v;
  import serial_add_pkg::*;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;
  logic i_clk = 0, i_rst = 1, i_start = 0, i_cin = 0, i_f;
  logic [W-1:0] i_a = '0, i_b = '0, o_sum;
  logic o_a, o_b, o_c, o_busy, o_done, o_cout;
  logic [1:0] o_code;
`ifdef SERIAL_ADD_SEQ_OVF_EN
  logic o_ovf;
`endif
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, busy_run = 0;
  logic [W-1:0] last_sum = '0;
  logic last_cout = 1'b0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  full_adder_v u_fa (.a(o_a), .b(o_b), .c(o_c), .code(o_code), .f(i_f));
  serial_add_seq_v #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_a(i_a), .i_b(i_b), .i_cin(i_cin),
    .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_code(o_code), .i_f(i_f),
`ifdef SERIAL_ADD_SEQ_OVF_EN
    .o_ovf(o_ovf),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_sum(o_sum), .o_cout(o_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT signals done
  always @(negedge i_clk) begin
    if (i_rst) begin
      busy_run = 0;
      last_sum = '0;
      last_cout = 1'b0;
    end else begin
      if (o_busy) begin
        chk("code_alt", o_code, (busy_run % 2 == 0) ? CODE_SUM : CODE_CARRY);
        chk("result_hold", {o_cout, o_sum}, {last_cout, last_sum});
        busy_run++;
      end
      if (o_done) begin
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with sum %0h, required no done", o_sum);
        end else begin
          mon_e = q.pop_front();
          chk("sum", o_sum, mon_e.sum);
          chk("cout", o_cout, mon_e.cout);
`ifdef SERIAL_ADD_SEQ_OVF_EN
          chk("ovf", o_ovf, mon_e.ovf);
`endif
          chk("latency", cyc - mon_e.acc, 2 * W);
          chk("busy_len", busy_run, 2 * W);
        end
        busy_run = 0;
        last_sum = o_sum;
        last_cout = o_cout;
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit push);
    logic [W:0] full;
    exp_t e;
    @(negedge i_clk);
    i_a = a; i_b = b; i_cin = cin; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_a = W'($urandom); i_b = W'($urandom); i_cin = 1'($urandom);
    if (push) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.sum = full[W-1:0];
      e.cout = full[W];
      e.ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_done;
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_done && n < 60);
    if (!o_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
    end
    @(negedge i_clk);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    start_op(a, b, cin, 1);
    wait_done();
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_sum", o_sum, 0);
    chk("rst_cout", o_cout, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_cell", {o_a, o_b, o_c, o_code}, {3'b000, CODE_SUM});
    @(negedge i_clk);
    i_rst = 1'b0;
    run_op(8'h35, 8'h4A, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h80, 8'h80, 1'b1);
    // a start arriving mid-operation must be dropped
    d0 = done_cnt;
    start_op(8'h10, 8'h20, 1'b0, 1);
    repeat (4) @(negedge i_clk);
    i_a = 8'hFF; i_b = 8'hFF; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_done();
    repeat (4) @(negedge i_clk);
    chk("single_done", done_cnt - d0, 1);
    chk("idle_after_ignored", o_busy, 0);
    // asynchronous abort mid-operation
    d0 = done_cnt;
    start_op(8'h5A, 8'h3C, 1'b1, 0);
    repeat (6) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    chk("abort_sum", o_sum, 0);
    chk("abort_cout", o_cout, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_cell", {o_a, o_b, o_c, o_code}, {3'b000, CODE_SUM});
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (20) @(negedge i_clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_op(8'h5A, 8'h3C, 1'b1);
    for (int i = 0; i < 25; i++) run_op(W'($urandom), W'($urandom), 1'($urandom));
    repeat (3) @(negedge i_clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_add_seq_v.md
Name: serial_add_seq_v

Overview:
- Bit-serial adder sequencer; sits directly upstream of, and also consumes results from, the combinational full_adder_v cell.
- Per operand bit, it time-multiplexes one full_adder_v instance:
  - First it asks the cell for the sum bit.
  - Then it asks for the carry bit.
  - It registers both responses.
- Assembles a WIDTH-bit sum plus carry-out and signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CODE_SUM, 2'b00, function code that makes the cell output the sum bit on i_f.
- CODE_CARRY, 2'b01, function code that makes the cell output the carry bit on i_f.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  request a new addition; sampled only in IDLE.
- i_a  in  WIDTH  operand A; captured on the accepting edge.
- i_b  in  WIDTH  operand B; captured on the accepting edge.
- i_cin  in  1  carry-in; captured on the accepting edge.
- o_a  out  1  operand-A bit to the cell.
- o_b  out  1  operand-B bit to the cell.
- o_c  out  1  carry bit to the cell.
- o_code  out  2  function code to the cell.
- i_f  in  1  combinational result from the cell.
- o_busy  out  1  high while an addition is in progress.
- o_done  out  1  one-cycle pulse when o_sum/o_cout update.
- o_sum  out  WIDTH  registered result.
- o_cout  out  1  registered carry-out.

Behaviour:
- Reset state: FSM IDLE, shift registers, carry flop and bit counter cleared; o_busy=0, o_done=0, o_sum=0, o_cout=0.
- Cell drive while reset is asserted or in IDLE/DONE: o_a=0, o_b=0, o_c=0, o_code=CODE_SUM.
- Reset mid-operation aborts immediately to the reset state; no done pulse is emitted.
- FSM states: IDLE, SUM, CARRY, DONE.
- IDLE:
  - i_start=1 at an edge loads a_sh=i_a, b_sh=i_b, carry=i_cin, bit counter=0, then goes to SUM.
  - i_start=0 stays in IDLE.
- SUM:
  - Drives o_a=a_sh[0], o_b=b_sh[0], o_c=carry, o_code=CODE_SUM.
  - At the edge, shifts i_f into the MSB of the sum shift register (right shift), then goes to CARRY.
- CARRY:
  - Same o_a/o_b/o_c as SUM; o_code=CODE_CARRY.
  - At the edge: carry<=i_f; a_sh, b_sh shift right by 1; counter increments.
  - If counter was WIDTH-1, goes to DONE and loads o_sum<=final sum register, o_cout<=i_f.
  - Otherwise returns to SUM.
- DONE: o_done=1 for exactly one cycle, then unconditionally returns to IDLE. i_start is ignored in DONE.
- o_busy=1 in SUM and CARRY only.
- i_start in SUM/CARRY/DONE is ignored, not queued.
- Latency:
  - Accepting edge k.
  - Evaluation edges k+1..k+2*WIDTH.
  - o_done high in the cycle after edge k+2*WIDTH.
  - Next start is accepted no earlier than edge k+2*WIDTH+2.
- o_sum/o_cout hold the previous result throughout a new computation; they change only on entry to DONE.
- Arithmetic is unsigned modulo 2^WIDTH, with o_cout the true carry-out of {i_a}+{i_b}+i_cin.
- i_a/i_b changes after acceptance have no effect.

Optional Feature:
- Macro SERIAL_ADD_SEQ_OVF_EN.
- Defined:
  - Adds output o_ovf (out, 1), the signed two's-complement overflow: carry into MSB XOR carry out of MSB.
  - Captured in the CARRY state of bit WIDTH-1, using the carry flop value before update XOR i_f.
  - Loaded on entry to DONE, reset 0, held like o_sum.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_add_pkg: FSM state encoding constants (IDLE=2'd0, SUM=2'd1, CARRY=2'd2, DONE=2'd3), and default CODE_SUM/CODE_CARRY constants reused by full_adder_v benches.
- One sub-module, serial_add_shreg_v: a parallel-load, right-shift register with load/shift enables and serial in/out, instantiated three times (A, B, sum).
- The bench instantiates full_adder_v alongside and wires o_a/o_b/o_c/o_code/i_f to it.

Test Plan:
- WIDTH=8, i_a=8'h35, i_b=8'h4A, i_cin=0, i_start pulse -> o_done exactly 16 edges after acceptance; o_sum=8'h7F, o_cout=0, o_busy high for 16 cycles.
- i_a=8'hFF, i_b=8'h01, i_cin=0 -> o_sum=8'h00, o_cout=1; with SERIAL_ADD_SEQ_OVF_EN, o_ovf=0.
- i_a=8'h7F, i_b=8'h01, i_cin=0 with SERIAL_ADD_SEQ_OVF_EN -> o_sum=8'h80, o_cout=0, o_ovf=1.
- i_a=0, i_b=0, i_cin=1 -> o_sum=8'h01, o_cout=0. Also check o_code alternates CODE_SUM/CODE_CARRY on every edge while busy.
- Start 8'h10+8'h20, then pulse i_start with 8'hFF+8'hFF at cycle 5 -> second request ignored; o_sum=8'h30, exactly one o_done.
- Assert i_rst at cycle 7 of an addition -> all outputs 0 asynchronously, no o_done. A fresh start after release yields the correct result.
